// File: rtl/packet_pkg.sv
// -----------------------------------------------------------------------------
// packet_pkg
// Shared definitions for the packet path (scheduler, framer, bus interface).
//   PKT_NBYTES     : bytes per framed packet, header and stop byte included
//   PKT_DATA_WIDTH : payload width carried by one packet
//   pkt_state_t    : scheduler FSM states
// -----------------------------------------------------------------------------
package packet_pkg;

    localparam int PKT_NBYTES     = 8;
    localparam int PKT_DATA_WIDTH = 54;

    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } pkt_state_t;

endpackage

// File: rtl/rr_arbiter.sv
// -----------------------------------------------------------------------------
// rr_arbiter
// Combinational round-robin arbiter. Searches the request vector starting at
// ptr_i and wrapping, and grants the first active requester.
// Ports:
//   req_i  in  NREQ  request vector
//   ptr_i  in  IW    highest-priority index for this search (must be < NREQ)
//   en_i   in  1     when low no grant is issued
//   gnt_o  out NREQ  one-hot grant (all zero when en_i low or no request)
//   idx_o  out IW    encoded index of the granted requester (0 when no grant)
// -----------------------------------------------------------------------------
module rr_arbiter #(
    parameter int NREQ = 4,
    parameter int IW   = $clog2(NREQ)
) (
    input  logic [NREQ-1:0] req_i,
    input  logic [IW-1:0]   ptr_i,
    input  logic            en_i,
    output logic [NREQ-1:0] gnt_o,
    output logic [IW-1:0]   idx_o
);

    // One extra bit so ptr + offset cannot overflow before the wrap.
    logic [IW:0] cand;
    logic        found;

    always_comb begin
        gnt_o = '0;
        idx_o = '0;
        found = 1'b0;
        cand  = '0;
        for (int k = 0; k < NREQ; k++) begin
            cand = {1'b0, ptr_i} + (IW+1)'(k);
            if (cand >= (IW+1)'(NREQ)) begin
                cand = cand - (IW+1)'(NREQ);
            end
            if (!found && en_i && req_i[cand[IW-1:0]]) begin
                found                = 1'b1;
                gnt_o[cand[IW-1:0]]  = 1'b1;
                idx_o                = cand[IW-1:0];
            end
        end
    end

endmodule

// File: rtl/packet_sched.sv
// -----------------------------------------------------------------------------
// packet_sched
// Round-robin scheduler sharing one packet framer among NREQ producers. A
// granted word is held on pkt_di while pkt_en runs for exactly NBYTES cycles;
// packets chain back-to-back when the next grant lands on the last byte.
// Ports:
//   clk, rst_n   clock, asynchronous active-low reset
//   enable       permits new grants (current packet always completes)
//   req_valid    per-requester valid
//   req_data     requester i at [i*DATA_WIDTH +: DATA_WIDTH]
//   req_ready    one-hot, combinational
//   space_ok     downstream can take a whole packet; looked at only at grant
//   pkt_en       framer enable (registered)
//   pkt_di       held word for the framer (registered)
//   pkt_src      owner of the current packet
//   byte_valid   qualifies the framer byte output (equals pkt_en)
//   byte_idx     index of the byte on the framer output
//   pkt_last     last byte of the packet is on the output
//   dbg_state    FSM state (1 = SEND)
//
// Handshake: req_ready[i] is asserted only when requester i wins arbitration in
// a grant window with enable and space_ok high; the transfer happens on the
// rising edge where req_valid[i] & req_ready[i]. Data is sampled on that edge
// only, so the requester may change req_data afterwards.
// -----------------------------------------------------------------------------
module packet_sched
    import packet_pkg::*;
#(
    parameter int NREQ       = 4,
    parameter int DATA_WIDTH = PKT_DATA_WIDTH,
    parameter int NBYTES     = PKT_NBYTES
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       enable,
    input  logic [NREQ-1:0]            req_valid,
    input  logic [NREQ*DATA_WIDTH-1:0] req_data,
    output logic [NREQ-1:0]            req_ready,
    input  logic                       space_ok,
    output logic                       pkt_en,
    output logic [DATA_WIDTH-1:0]      pkt_di,
    output logic [$clog2(NREQ)-1:0]    pkt_src,
    output logic                       byte_valid,
    output logic [$clog2(NBYTES)-1:0]  byte_idx,
    output logic                       pkt_last,
    output logic                       dbg_state
);

    localparam int SW = $clog2(NREQ);
    localparam int BW = $clog2(NBYTES);
    localparam logic [BW-1:0] LAST_IDX = BW'(NBYTES - 1);
    localparam logic [SW-1:0] LAST_SRC = SW'(NREQ - 1);

    pkt_state_t            state_q, state_d;
    logic [BW-1:0]         idx_q, idx_d;
    logic [DATA_WIDTH-1:0] di_q, di_d;
    logic [SW-1:0]         src_q, src_d;
    logic [SW-1:0]         ptr_q, ptr_d;
    logic                  en_q, en_d;

    logic                  at_last;
    logic                  grant_window;
    logic                  arb_en;
    logic                  handshake;
    logic [NREQ-1:0]       gnt;
    logic [SW-1:0]         gnt_idx;

    assign at_last      = (state_q == SEND) && (idx_q == LAST_IDX);
    assign grant_window = (state_q == IDLE) || at_last;
    // rst_n gates the arbiter so req_ready stays low throughout reset.
    assign arb_en       = rst_n && grant_window && enable && space_ok;

    rr_arbiter #(
        .NREQ (NREQ),
        .IW   (SW)
    ) u_arb (
        .req_i (req_valid),
        .ptr_i (ptr_q),
        .en_i  (arb_en),
        .gnt_o (gnt),
        .idx_o (gnt_idx)
    );

    assign req_ready = gnt;
    assign handshake = |(req_valid & gnt);

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        di_d    = di_q;
        src_d   = src_q;
        ptr_d   = ptr_q;
        en_d    = en_q;

        case (state_q)
            IDLE: begin
                if (handshake) begin
                    state_d = SEND;
                    en_d    = 1'b1;
                    idx_d   = '0;
                end
            end
            SEND: begin
                if (at_last) begin
                    // Wrap to 0 either way: a chained grant starts the next
                    // packet, otherwise the framer counter clears with pkt_en.
                    idx_d = '0;
                    if (!handshake) begin
                        state_d = IDLE;
                        en_d    = 1'b0;
                    end
                end else begin
                    idx_d = idx_q + BW'(1);
                end
            end
            default: begin
                state_d = IDLE;
                en_d    = 1'b0;
                idx_d   = '0;
            end
        endcase

        if (handshake) begin
            di_d  = req_data[int'(gnt_idx)*DATA_WIDTH +: DATA_WIDTH];
            src_d = gnt_idx;
            ptr_d = (gnt_idx == LAST_SRC) ? '0 : gnt_idx + SW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            idx_q   <= '0;
            di_q    <= '0;
            src_q   <= '0;
            ptr_q   <= '0;
            en_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            di_q    <= di_d;
            src_q   <= src_d;
            ptr_q   <= ptr_d;
            en_q    <= en_d;
        end
    end

    assign pkt_en     = en_q;
    assign byte_valid = en_q;
    assign pkt_di     = di_q;
    assign pkt_src    = src_q;
    assign byte_idx   = idx_q;
    assign pkt_last   = en_q && (idx_q == LAST_IDX);
    assign dbg_state  = (state_q == SEND);

endmodule

// File: tb/tb_packet_sched.sv
// -----------------------------------------------------------------------------
// tb_packet_sched
// Self-checking bench for packet_sched (NREQ=4, 54-bit data, 8-byte packets).
// A cycle model written in terms of "bytes left in the current packet" predicts
// req_ready and all registered outputs; granted words go into a scoreboard
// queue and are popped when the DUT shows byte 0 of a packet.
// -----------------------------------------------------------------------------
module tb_packet_sched;
    import packet_pkg::*;

    localparam int NREQ = 4;
    localparam int DW   = PKT_DATA_WIDTH;
    localparam int NB   = PKT_NBYTES;
    localparam int SBW  = 2 + DW;

    // ---------------- clock / reset ----------------
    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    logic                 enable;
    logic                 space_ok;
    logic [NREQ-1:0]      req_valid;
    logic [NREQ*DW-1:0]   req_data;
    logic [NREQ-1:0]      req_ready;
    logic                 pkt_en;
    logic [DW-1:0]        pkt_di;
    logic [1:0]           pkt_src;
    logic                 byte_valid;
    logic [2:0]           byte_idx;
    logic                 pkt_last;
    logic                 dbg_state;

    logic [DW-1:0]        req_words [NREQ];

    always_comb begin
        req_data = '0;
        for (int i = 0; i < NREQ; i++) req_data[i*DW +: DW] = req_words[i];
    end

    packet_sched #(
        .NREQ       (NREQ),
        .DATA_WIDTH (DW),
        .NBYTES     (NB)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .enable     (enable),
        .req_valid  (req_valid),
        .req_data   (req_data),
        .req_ready  (req_ready),
        .space_ok   (space_ok),
        .pkt_en     (pkt_en),
        .pkt_di     (pkt_di),
        .pkt_src    (pkt_src),
        .byte_valid (byte_valid),
        .byte_idx   (byte_idx),
        .pkt_last   (pkt_last),
        .dbg_state  (dbg_state)
    );

    // ---------------- scoreboard / model state ----------------
    logic [SBW-1:0]  exp_q[$];
    int              seen_src[$];
    int              n_checks = 0;
    int              n_pass   = 0;
    int              m_left   = 0;
    int              m_ptr    = 0;
    int              m_src    = 0;
    logic [DW-1:0]   m_di     = '0;
    logic [NREQ-1:0] last_ready;
    int              en_cycles;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    function automatic logic [DW-1:0] rnd54();
        logic [63:0] r;
        r = {$urandom(), $urandom()};
        return r[DW-1:0];
    endfunction

    task automatic model_reset();
        m_left = 0;
        m_ptr  = 0;
        m_src  = 0;
        m_di   = '0;
        exp_q.delete();
    endtask

    task automatic model_pred(output logic g, output int gi);
        int c;
        g  = 1'b0;
        gi = 0;
        if (rst_n && m_left <= 1 && enable && space_ok) begin
            for (int k = 0; k < NREQ; k++) begin
                c = (m_ptr + k) % NREQ;
                if (!g && req_valid[c]) begin
                    g  = 1'b1;
                    gi = c;
                end
            end
        end
    endtask

    task automatic check_outputs(input string tag);
        int ei;
        ei = (m_left != 0) ? NB - m_left : 0;
        chk({tag, "_pkt_en"},     64'(pkt_en),     64'(m_left != 0));
        chk({tag, "_byte_valid"}, 64'(byte_valid), 64'(m_left != 0));
        chk({tag, "_dbg_state"},  64'(dbg_state),  64'(m_left != 0));
        chk({tag, "_byte_idx"},   64'(byte_idx),   64'(ei));
        chk({tag, "_pkt_last"},   64'(pkt_last),   64'(m_left == 1));
        chk({tag, "_pkt_src"},    64'(pkt_src),    64'(m_src));
        chk({tag, "_pkt_di"},     64'(pkt_di),     64'(m_di));
    endtask

    task automatic reset_check(input string tag);
        chk({tag, "_req_ready"},  64'(req_ready),  64'(0));
        chk({tag, "_pkt_en"},     64'(pkt_en),     64'(0));
        chk({tag, "_byte_valid"}, 64'(byte_valid), 64'(0));
        chk({tag, "_pkt_last"},   64'(pkt_last),   64'(0));
        chk({tag, "_byte_idx"},   64'(byte_idx),   64'(0));
        chk({tag, "_pkt_di"},     64'(pkt_di),     64'(0));
        chk({tag, "_pkt_src"},    64'(pkt_src),    64'(0));
        chk({tag, "_dbg_state"},  64'(dbg_state),  64'(0));
    endtask

    // One clock cycle: check req_ready before the edge, advance, check after.
    task automatic cycle();
        logic            g;
        int              gi;
        logic [NREQ-1:0] er;
        logic [DW-1:0]   gword;
        logic [SBW-1:0]  item;
        #1;
        model_pred(g, gi);
        er = '0;
        if (g) er[gi] = 1'b1;
        last_ready = req_ready;
        chk("req_ready", 64'(req_ready), 64'(er));
        gword = req_words[gi];
        if (g) exp_q.push_back({2'(gi), gword});
        @(posedge clk);
        if (g) begin
            m_left = NB;
            m_src  = gi;
            m_di   = gword;
            m_ptr  = (gi + 1) % NREQ;
        end else if (m_left > 0) begin
            m_left--;
        end
        #1;
        check_outputs("cyc");
        if (pkt_en) en_cycles++;
        if (pkt_en && byte_idx == 3'd0) begin
            seen_src.push_back(int'(pkt_src));
            if (exp_q.size() == 0) begin
                n_checks++;
                $display("FAIL sb_underflow: packet from src %0d with no expected entry", pkt_src);
            end else begin
                item = exp_q.pop_front();
                chk("sb_src",  64'(pkt_src), 64'(item[SBW-1:DW]));
                chk("sb_data", 64'(pkt_di),  64'(item[DW-1:0]));
            end
        end
    endtask

    task automatic run_until_idle(input int bound);
        int n;
        n = 0;
        while ((pkt_en || m_left != 0) && n < bound) begin
            cycle();
            n++;
        end
        chk("idle_reached", 64'(pkt_en), 64'(0));
    endtask

    // ---------------- vectors ----------------
    typedef struct {
        logic [NREQ-1:0] valid;
        logic            en;
        logic            sp;
        logic [DW-1:0]   data;
        logic [NREQ-1:0] exp_ready;
    } vec_t;

    vec_t vecs [10];
    int   exp_src [5];

    initial begin : wd
        #100000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        // Arbitration from idle; exp_ready derived by hand from rr_ptr history.
        vecs[0] = '{valid: 4'b0001, en: 1'b1, sp: 1'b1, data: 54'h2A_BCDE_F012_3456, exp_ready: 4'b0001}; // ptr 0->1
        vecs[1] = '{valid: 4'b1111, en: 1'b1, sp: 1'b0, data: rnd54(), exp_ready: 4'b0000};
        vecs[2] = '{valid: 4'b1111, en: 1'b0, sp: 1'b1, data: rnd54(), exp_ready: 4'b0000};
        vecs[3] = '{valid: 4'b0000, en: 1'b1, sp: 1'b1, data: rnd54(), exp_ready: 4'b0000};
        vecs[4] = '{valid: 4'b0001, en: 1'b1, sp: 1'b1, data: rnd54(), exp_ready: 4'b0001}; // ptr 1->1
        vecs[5] = '{valid: 4'b1101, en: 1'b1, sp: 1'b1, data: rnd54(), exp_ready: 4'b0100}; // ptr 1->3
        vecs[6] = '{valid: 4'b0111, en: 1'b1, sp: 1'b1, data: rnd54(), exp_ready: 4'b0001}; // ptr 3->1
        vecs[7] = '{valid: 4'b1000, en: 1'b1, sp: 1'b1, data: rnd54(), exp_ready: 4'b1000}; // ptr 1->0
        vecs[8] = '{valid: 4'b1010, en: 1'b1, sp: 1'b1, data: rnd54(), exp_ready: 4'b0010}; // ptr 0->2
        vecs[9] = '{valid: 4'b0011, en: 1'b1, sp: 1'b1, data: rnd54(), exp_ready: 4'b0001}; // ptr 2->1
        exp_src = '{1, 2, 3, 0, 1};

        enable    = 1'b0;
        space_ok  = 1'b0;
        req_valid = '0;
        for (int i = 0; i < NREQ; i++) req_words[i] = '0;
        en_cycles = 0;
        model_reset();

        // Power-on reset.
        rst_n = 1'b0;
        #1;
        reset_check("por");
        repeat (2) @(posedge clk);
        #1;
        rst_n    = 1'b1;
        enable   = 1'b1;
        space_ok = 1'b1;

        // Table-driven single-packet transactions.
        for (int v = 0; v < 10; v++) begin
            req_valid = vecs[v].valid;
            enable    = vecs[v].en;
            space_ok  = vecs[v].sp;
            for (int i = 0; i < NREQ; i++) req_words[i] = vecs[v].data ^ DW'(i);
            en_cycles = 0;
            cycle();
            chk($sformatf("vec%0d_ready", v), 64'(last_ready), 64'(vecs[v].exp_ready));
            req_valid = '0;
            enable    = 1'b1;
            space_ok  = 1'b1;
            run_until_idle(20);
            chk($sformatf("vec%0d_len", v), 64'(en_cycles),
                64'((vecs[v].exp_ready != '0) ? NB : 0));
        end

        // Back-to-back, all requesting; data changes every cycle mid-packet.
        seen_src.delete();
        req_valid = 4'b1111;
        for (int i = 0; i < NREQ; i++) req_words[i] = rnd54();
        cycle();
        n = 0;
        for (int c = 0; c < 4 * NB; c++) begin
            for (int i = 0; i < NREQ; i++) req_words[i] = rnd54();
            cycle();
            if (!pkt_en) n++;
        end
        chk("b2b_gaps", 64'(n), 64'(0));
        chk("b2b_starts", 64'(seen_src.size()), 64'(5));
        for (int i = 0; i < 5 && i < seen_src.size(); i++)
            chk($sformatf("b2b_src%0d", i), 64'(seen_src[i]), 64'(exp_src[i]));
        req_valid = '0;
        run_until_idle(20);

        // enable dropped at byte 3: packet finishes, then idles.
        req_valid = 4'b1111;
        n = 0;
        while (!(pkt_en && byte_idx == 3'd3) && n < 20) begin
            cycle();
            n++;
        end
        chk("en_drop_reached_b3", 64'(byte_idx), 64'(3));
        enable    = 1'b0;
        en_cycles = 0;
        repeat (12) cycle();
        chk("en_drop_tail", 64'(en_cycles), 64'(4));
        chk("en_drop_idle", 64'(pkt_en), 64'(0));
        chk("en_drop_ready", 64'(last_ready), 64'(0));
        enable    = 1'b1;
        req_valid = '0;
        run_until_idle(20);

        // space_ok low blocks grants; rising grants at once (ptr is 3 here).
        req_valid = 4'b0110;
        space_ok  = 1'b0;
        repeat (4) cycle();
        chk("space_blocked", 64'(last_ready), 64'(0));
        space_ok = 1'b1;
        cycle();
        chk("space_grant", 64'(last_ready), 64'(4'b0010));
        chk("space_b0_en", 64'(pkt_en), 64'(1));
        chk("space_b0_idx", 64'(byte_idx), 64'(0));
        req_valid = '0;
        run_until_idle(20);

        // Reset pulse at byte 4 aborts the packet.
        req_valid = 4'b0001;
        n = 0;
        while (!(pkt_en && byte_idx == 3'd4) && n < 20) begin
            cycle();
            n++;
        end
        chk("rst_reached_b4", 64'(byte_idx), 64'(4));
        req_valid = 4'b1111;
        rst_n     = 1'b0;
        #1;
        reset_check("mid_rst");
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        reset_check("hold_rst");
        rst_n     = 1'b1;
        req_valid = 4'b0100;
        req_words[2] = rnd54();
        cycle();
        chk("post_rst_ready", 64'(last_ready), 64'(4'b0100));
        chk("post_rst_b0_en", 64'(pkt_en), 64'(1));
        chk("post_rst_b0_idx", 64'(byte_idx), 64'(0));
        req_valid = '0;
        run_until_idle(20);

        chk("sb_drain", 64'(exp_q.size()), 64'(0));

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/packet_sched.md
# packet_sched

Round-robin scheduler that shares one packet framer among `NREQ` sample producers. It accepts one 54-bit word from a requester through a valid/ready handshake and holds it on the framer's data input. It drives the framer's enable for exactly `NBYTES` cycles per packet and qualifies the framer's byte output for the downstream 8-bit bus interface. Packets run back-to-back with no idle cycle whenever a request and downstream space are both available.

## Interface
Parameters:
- `NREQ`, 4: number of requesters, 2..8.
- `DATA_WIDTH`, 54: payload width per request; must equal the framer's input width.
- `NBYTES`, 8: bytes per framed packet, including the header and stop bytes.

Ports:
- `clk`  in  1  sole clock.
- `rst_n`  in  1  asynchronous, active-low reset.
- `enable`  in  1  high permits new grants; low lets the current packet finish and then idles.
- `req_valid`  in  NREQ  per-requester data-valid.
- `req_data`  in  NREQ*DATA_WIDTH  requester i occupies bits [i*DATA_WIDTH +: DATA_WIDTH].
- `req_ready`  out  NREQ  one-hot, combinational; handshake completes on the edge where `req_valid[i] & req_ready[i]`.
- `space_ok`  in  1  downstream can absorb at least `NBYTES` bytes; sampled only at grant.
- `pkt_en`  out  1  registered; connects to the framer `en`.
- `pkt_di`  out  DATA_WIDTH  registered held word; connects to the framer `di`.
- `pkt_src`  out  $clog2(NREQ)  index of the requester owning the current packet.
- `byte_valid`  out  1  registered, equal to `pkt_en`; qualifies the framer byte output.
- `byte_idx`  out  $clog2(NBYTES)  index of the byte currently on the framer output; mirrors the framer counter.
- `pkt_last`  out  1  high while `byte_idx == NBYTES-1` and `pkt_en` is high.

## Operation
- States: IDLE and SEND.
- Grant window: the block is in IDLE, or in SEND with `byte_idx == NBYTES-1`.
- Grant condition: grant window, and `enable`, and `space_ok`, and any `req_valid`.
- Arbitration: round-robin starting at `rr_ptr`. On a grant to requester i, `rr_ptr` becomes (i+1) mod `NREQ`.
- `req_ready` is zero outside the grant condition. At most one bit is ever set.
- On the handshake edge:
  - `pkt_di` loads the selected data and `pkt_src` loads i.
  - `byte_idx` loads 0.
  - `pkt_en` goes 1 and the state goes to SEND.
- SEND: `byte_idx` increments each cycle.
- At `byte_idx == NBYTES-1` with no grant, the next state is IDLE and `pkt_en` goes 0. With a grant, SEND continues, `byte_idx` wraps to 0 and new data loads, all in one edge. The framer counter wraps on the same edge.
- `pkt_di` holds its value in IDLE and is never changed mid-packet.
- `enable` and `space_ok` deasserting mid-packet have no effect until the next grant window.

## Timing
- Reset (asynchronous assert): `pkt_en`=0, `byte_valid`=0, `pkt_last`=0, `byte_idx`=0, `pkt_di`=0, `pkt_src`=0, `rr_ptr`=0, state IDLE.
- `req_ready` is 0 during reset.
- Reset during SEND aborts the packet. `pkt_en` low clears the framer counter on the next `clk` edge, so the first packet after reset starts from byte 0.
- Latency: handshake at edge t puts byte 0 on the bus in cycle t+1. The last byte is in cycle t+`NBYTES`.
- Throughput: one packet per `NBYTES` cycles, sustained, with zero gap.
- There is at least one cycle with `pkt_en` low after reset deassertion, since no grant occurs in the reset cycle.
- Requester data is sampled only at the handshake. The requester may change `req_data` freely afterward.

## Structure
- Shared package `packet_pkg`:
  - `PKT_NBYTES` = 8.
  - `PKT_DATA_WIDTH` = 54.
  - state enum `{IDLE, SEND}`.
  - The same package is used by the framer and the bus interface.
- One sub-module: `rr_arbiter`. It is parameterized by `NREQ` and maps (`req`, `ptr`, `en`) to a one-hot grant and an encoded index.
- `packet_sched` contains the FSM, the byte counter and the hold register.

## Test plan
- Single request: `req_valid`=0001, data 0x2A_BCDE_F012_3456, `space_ok`=1 → `req_ready[0]` for one cycle. `pkt_en` is high for exactly 8 cycles with `byte_idx` 0..7. `pkt_last` is high in cycle 8. The framer bytes match the header, six data bytes and 0x00.
- All four requesting continuously → grants go 0,1,2,3,0 with `pkt_en` never dropping. Each `byte_idx` 7 is followed directly by 0 and a new `pkt_src`.
- `space_ok`=0 while requests are pending → no `req_ready`. `space_ok` rising → grant on that cycle and byte 0 one cycle later.
- `enable` dropped at `byte_idx`=3 → the packet completes through byte 7 and the block then idles despite `req_valid`=1111.
- `rst_n` pulsed low at `byte_idx`=4 → all outputs are 0 immediately. After release, the next grant yields byte 0 with the header byte first.
- Requester changes `req_data` during SEND → `pkt_di` is unchanged until the next handshake.
